// File: rtl/dac_config_seq.sv
// SPI configuration sequencer for the FMC151 DAC: after a power-up delay it writes a
// parent-supplied register table as 16-bit mode-0 frames, then raises dac_en.
// Optional readback pass enabled by defining DAC_READBACK_EN.
module dac_config_seq #(
    parameter int NUM_WRITES  = 20,
    parameter int SCLK_DIV    = 4,
    parameter int START_DELAY = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    output logic [4:0]  o_tbl_idx,
    input  logic [15:0] i_tbl_word,
    output logic        o_spi_cs_n,
    output logic        o_spi_sclk,
    output logic        o_spi_sdo,
    input  logic        i_spi_sdi,
    output logic        o_busy,
    output logic        o_dac_en,
    output logic        o_error,
    output logic [4:0]  o_err_idx
);

    // FETCH and LOAD already keep cs_n high for two cycles, so GAP only adds the remainder.
    localparam int         GAP_CYC  = (SCLK_DIV > 1) ? (2 * SCLK_DIV - 2) : 1;
    localparam int         CNT_MAX  = (START_DELAY > 2 * SCLK_DIV) ? START_DELAY : 2 * SCLK_DIV;
    localparam int         CNT_W    = $clog2(CNT_MAX + 1);
    localparam logic [4:0] LAST_IDX = 5'(NUM_WRITES - 1);

    typedef enum logic [3:0] {
        S_WAIT     = 4'd0,
        S_FETCH    = 4'd1,
        S_LOAD     = 4'd2,
        S_SHIFT    = 4'd3,
        S_GAP      = 4'd4,
`ifdef DAC_READBACK_EN
        S_RB_FETCH = 4'd5,
        S_RB_LOAD  = 4'd6,
        S_RB_SHIFT = 4'd7,
        S_RB_GAP   = 4'd8,
`endif
        S_DONE     = 4'd9
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [4:0]         r_half;
    logic [14:0]        r_sr;
    logic [4:0]         r_idx;
    logic               r_cs_n;
    logic               r_sclk;
    logic               r_sdo;
    logic               r_busy;
    logic               r_dac_en;

    logic               w_in_load;
    logic               w_in_shift;
    logic               w_in_gap;
    logic               w_rd_pass;
    logic               w_tick;
    logic               w_frame_end;
    logic               w_gap_end;
    logic               w_last;
    logic               w_unused;

`ifdef DAC_READBACK_EN
    assign w_in_load  = (r_state == S_LOAD)  || (r_state == S_RB_LOAD);
    assign w_in_shift = (r_state == S_SHIFT) || (r_state == S_RB_SHIFT);
    assign w_in_gap   = (r_state == S_GAP)   || (r_state == S_RB_GAP);
    assign w_rd_pass  = (r_state == S_RB_LOAD);
`else
    assign w_in_load  = (r_state == S_LOAD);
    assign w_in_shift = (r_state == S_SHIFT);
    assign w_in_gap   = (r_state == S_GAP);
    assign w_rd_pass  = 1'b0;
`endif

    assign w_tick      = (r_cnt == CNT_W'(SCLK_DIV - 1));
    assign w_frame_end = w_in_shift && w_tick && r_sclk && (r_half == 5'd31);
    assign w_gap_end   = w_in_gap && (r_cnt == CNT_W'(GAP_CYC - 1));
    assign w_last      = (r_idx == LAST_IDX);
    // Bit 15 is always replaced by the pass direction; sdi matters only with readback.
    assign w_unused    = ^{i_tbl_word[15], i_spi_sdi};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WAIT: begin
                if (r_cnt == CNT_W'(START_DELAY - 1)) w_state_nxt = S_FETCH;
                else                                  w_state_nxt = S_WAIT;
            end
            S_FETCH: w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (w_frame_end) w_state_nxt = S_GAP;
                else             w_state_nxt = S_SHIFT;
            end
            S_GAP: begin
                if (w_gap_end && w_last) begin
`ifdef DAC_READBACK_EN
                    w_state_nxt = S_RB_FETCH;
`else
                    w_state_nxt = S_DONE;
`endif
                end else if (w_gap_end) begin
                    w_state_nxt = S_FETCH;
                end else begin
                    w_state_nxt = S_GAP;
                end
            end
`ifdef DAC_READBACK_EN
            S_RB_FETCH: w_state_nxt = S_RB_LOAD;
            S_RB_LOAD:  w_state_nxt = S_RB_SHIFT;
            S_RB_SHIFT: begin
                if (w_frame_end) w_state_nxt = S_RB_GAP;
                else             w_state_nxt = S_RB_SHIFT;
            end
            S_RB_GAP: begin
                if (w_gap_end && w_last) w_state_nxt = S_DONE;
                else if (w_gap_end)      w_state_nxt = S_RB_FETCH;
                else                     w_state_nxt = S_RB_GAP;
            end
`endif
            S_DONE: begin
                if (i_start) w_state_nxt = S_FETCH;
                else         w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_WAIT;
        endcase
    end

    // Shared cycle counter, table index, SPI shifter and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_half   <= 5'd0;
            r_sr     <= 15'd0;
            r_idx    <= 5'd0;
            r_cs_n   <= 1'b1;
            r_sclk   <= 1'b0;
            r_sdo    <= 1'b0;
            r_busy   <= 1'b1;
            r_dac_en <= 1'b0;
        end else begin
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (w_in_shift && w_tick) begin
                r_cnt <= '0;
            end else if (r_state != S_DONE) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_state_nxt == S_FETCH && r_state != S_FETCH) begin
                r_idx <= (r_state == S_GAP) ? (r_idx + 5'd1) : 5'd0;
`ifdef DAC_READBACK_EN
            end else if (w_state_nxt == S_RB_FETCH && r_state != S_RB_FETCH) begin
                r_idx <= (r_state == S_RB_GAP) ? (r_idx + 5'd1) : 5'd0;
`endif
            end

            // Bit 15 goes straight to sdo at LOAD; only bits 14:0 need the shifter.
            if (w_in_load) begin
                r_sr   <= i_tbl_word[14:0];
                r_sdo  <= w_rd_pass;
                r_cs_n <= 1'b0;
                r_sclk <= 1'b0;
                r_half <= 5'd0;
            end else if (w_in_shift && w_tick) begin
                r_sclk <= ~r_sclk;
                r_half <= r_half + 5'd1;
                if (r_sclk && (r_half == 5'd31)) begin
                    r_cs_n <= 1'b1;
                    r_sdo  <= 1'b0;
                end else if (r_sclk) begin
                    r_sdo <= r_sr[14];
                    r_sr  <= {r_sr[13:0], 1'b0};
                end
            end

            r_busy   <= (w_state_nxt != S_DONE);
            r_dac_en <= (w_state_nxt == S_DONE);
        end
    end

`ifdef DAC_READBACK_EN
    logic [7:0] r_rx;
    logic [7:0] r_data;
    logic       r_error;
    logic [4:0] r_err_idx;

    // Readback capture on the last eight rising SCLK edges and first-mismatch latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx      <= 8'd0;
            r_data    <= 8'd0;
            r_error   <= 1'b0;
            r_err_idx <= 5'd0;
        end else begin
            if (w_in_load) begin
                r_data <= i_tbl_word[7:0];
            end
            if ((r_state == S_RB_SHIFT) && w_tick && !r_sclk && r_half[4]) begin
                r_rx <= {r_rx[6:0], i_spi_sdi};
            end
            if ((r_state == S_DONE) && i_start) begin
                r_error <= 1'b0;
            end else if ((r_state == S_RB_SHIFT) && w_frame_end && (r_rx != r_data) && !r_error) begin
                r_error   <= 1'b1;
                r_err_idx <= r_idx;
            end
        end
    end

    assign o_error   = r_error;
    assign o_err_idx = r_err_idx;
`else
    assign o_error   = 1'b0;
    assign o_err_idx = 5'd0;
`endif

    assign o_tbl_idx  = r_idx;
    assign o_spi_cs_n = r_cs_n;
    assign o_spi_sclk = r_sclk;
    assign o_spi_sdo  = r_sdo;
    assign o_busy     = r_busy;
    assign o_dac_en   = r_dac_en;

endmodule

// File: tb/tb_dac_config_seq.sv
// Directed bench for dac_config_seq: table-driven frame checks plus reset/start corner cases.
// Define DAC_READBACK_EN to also exercise the readback pass.
module tb_dac_config_seq;
    localparam int NW  = 4;
    localparam int SD  = 2;
    localparam int DLY = 16;
`ifdef DAC_READBACK_EN
    localparam int NF = 2 * NW;
`else
    localparam int NF = NW;
`endif

    typedef struct {
        logic [15:0] word;
        logic [15:0] exp;
    } vec_t;

    vec_t        vec [NW];
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sdi = 1'b0;
    logic [15:0] tbl_word = 16'd0;
    logic [4:0]  tbl_idx;
    logic        cs_n, sclk, sdo, busy, dac_en, error;
    logic [4:0]  err_idx;

    int n_checks = 0;
    int n_err = 0;
    int bad_entry = -1;

    dac_config_seq #(.NUM_WRITES(NW), .SCLK_DIV(SD), .START_DELAY(DLY)) dut (
        .clk(clk), .rst(rst), .i_start(start), .o_tbl_idx(tbl_idx), .i_tbl_word(tbl_word),
        .o_spi_cs_n(cs_n), .o_spi_sclk(sclk), .o_spi_sdo(sdo), .i_spi_sdi(sdi),
        .o_busy(busy), .o_dac_en(dac_en), .o_error(error), .o_err_idx(err_idx)
    );

    always #5 clk = ~clk;

    // Parent register table: one cycle of read latency.
    always @(posedge clk) tbl_word <= vec[tbl_idx[1:0]].word;

    logic        cs_prev = 1'b1;
    logic        sclk_prev = 1'b0;
    logic [15:0] cur_frame = 16'd0;
    logic [7:0]  resp;
    int          cur_rises = 0, low_cnt = 0, high_cnt = 0, frame_n = 0;
    logic [15:0] q_frame[$];
    int          q_rises[$], q_low[$], q_high[$];

    // SPI slave model: records frames and timing, echoes the data byte on reads.
    always @(negedge clk) begin
        if (cs_n === 1'b0) begin
            if (cs_prev) begin
                q_high.push_back(high_cnt);
                cur_frame = 16'd0;
                cur_rises = 0;
                low_cnt = 0;
            end
            low_cnt++;
            if (sclk && !sclk_prev) begin
                cur_frame = {cur_frame[14:0], sdo};
                cur_rises++;
            end
        end else begin
            if (!cs_prev) begin
                q_frame.push_back(cur_frame);
                q_rises.push_back(cur_rises);
                q_low.push_back(low_cnt);
                frame_n++;
                high_cnt = 0;
            end
            high_cnt++;
        end
        resp = 8'd0;
        if (frame_n >= NW && frame_n < 2 * NW && (frame_n - NW) != bad_entry)
            resp = vec[frame_n - NW].word[7:0];
        if (cs_n === 1'b0 && cur_rises >= 8 && cur_rises < 16) sdi = resp[15 - cur_rises];
        else sdi = 1'b0;
        cs_prev = cs_n;
        sclk_prev = sclk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        q_frame.delete();
        q_rises.delete();
        q_low.delete();
        q_high.delete();
        frame_n = 0;
    endtask

    task automatic measure_fall(input string name, input int exp);
        int n;
        n = 0;
        while (cs_n === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk(name, 32'(n), 32'(exp));
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 4000 && dac_en !== 1'b1; i++) tick();
        chk(name, 32'(dac_en), 32'd1);
        chk({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_frames(input string tag);
        logic [15:0] e;
        chk({tag, "_nframes"}, 32'(q_frame.size()), 32'(NF));
        for (int i = 0; i < NF && i < q_frame.size(); i++) begin
            e = (i < NW) ? vec[i].exp : (vec[i - NW].word | 16'h8000);
            chk($sformatf("%s_frame%0d", tag, i), 32'(q_frame[i]), 32'(e));
            chk($sformatf("%s_rises%0d", tag, i), 32'(q_rises[i]), 32'd16);
            chk($sformatf("%s_low%0d", tag, i), 32'(q_low[i]), 32'(32 * SD));
        end
        for (int i = 1; i < NF && i < q_high.size(); i++)
            chk($sformatf("%s_gap%0d", tag, i), 32'(q_high[i]), 32'(2 * SD));
    endtask

    initial begin
        vec[0] = '{16'h82A5, 16'h02A5};
        vec[1] = '{16'h0266, 16'h0266};
        vec[2] = '{16'h0377, 16'h0377};
        vec[3] = '{16'h0488, 16'h0488};

        repeat (3) tick();
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_sdo", 32'(sdo), 32'd0);
        chk("rst_tbl_idx", 32'(tbl_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_dac_en", 32'(dac_en), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_err_idx", 32'(err_idx), 32'd0);

        // Run 1: power-up delay, plus a start pulse mid-frame that must be ignored.
        clear_mon();
        @(negedge clk);
        rst = 1'b0;
        measure_fall("first_cs_fall", DLY + 2);
        chk("first_tbl_idx", 32'(tbl_idx), 32'd0);
        chk("first_busy", 32'(busy), 32'd1);
        repeat (10) tick();
        pulse_start();
        wait_done("run1_done");
        chk("run1_tbl_idx_hold", 32'(tbl_idx), 32'(NW - 1));
        chk("run1_error", 32'(error), 32'd0);
        repeat (20) tick();
        chk("run1_no_rerun", 32'(q_frame.size()), 32'(NF));
        check_frames("run1");

        // Run 2: start from DONE reruns immediately with a new table.
        vec[0] = '{16'h0155, 16'h0155};
        clear_mon();
        pulse_start();
        chk("restart_dac_en", 32'(dac_en), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        measure_fall("restart_cs_fall", 2);
        wait_done("run2_done");
        check_frames("run2");

        // Run 3: reset during bit 7 of frame 2 aborts and restarts from WAIT.
        clear_mon();
        pulse_start();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #1;
            if (frame_n == 2 && cur_rises == 9 && cs_n === 1'b0) break;
        end
        chk("abort_reached", 32'(cur_rises), 32'd9);
        rst = 1'b1;
        tick();
        chk("abort_cs_n", 32'(cs_n), 32'd1);
        chk("abort_sclk", 32'(sclk), 32'd0);
        chk("abort_busy", 32'(busy), 32'd1);
        chk("abort_tbl_idx", 32'(tbl_idx), 32'd0);
        tick();
        @(negedge clk);
        clear_mon();
        rst = 1'b0;
        measure_fall("abort_restart_fall", DLY + 2);
        wait_done("run3_done");
        check_frames("run3");

`ifdef DAC_READBACK_EN
        // Run 4: bad readback of entry 2 latches error and its index.
        bad_entry = 2;
        clear_mon();
        pulse_start();
        wait_done("rb_bad_done");
        chk("rb_bad_error", 32'(error), 32'd1);
        chk("rb_bad_err_idx", 32'(err_idx), 32'd2);
        check_frames("rb_bad");

        // Run 5: next start clears error; clean echo keeps it clear.
        bad_entry = -1;
        clear_mon();
        pulse_start();
        chk("rb_clear_error", 32'(error), 32'd0);
        wait_done("rb_good_done");
        chk("rb_good_error", 32'(error), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
